// File: rtl/vdisk_arb.sv
// Round-robin arbiter serialising NCH virtual-disk channels onto the single hps_io sector port.
// Optional abort-on-timeout is enabled by defining VDISK_ARB_TIMEOUT_EN.
module vdisk_arb #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 8,
  parameter int unsigned LBAW  = 32,
  parameter int unsigned TMO_W = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_rd,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*LBAW-1:0] ch_lba,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  input  logic [NCH*DW-1:0] ch_buff_din,
  output logic [NCH-1:0]    ch_buff_wr,
  output logic [AW-1:0]     ch_buff_addr,
  output logic [DW-1:0]     ch_buff_dout,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [LBAW-1:0]   sd_lba,
  input  logic              sd_ack,
  input  logic [AW-1:0]     sd_buff_addr,
  input  logic [DW-1:0]     sd_buff_dout,
  output logic [DW-1:0]     sd_buff_din,
  input  logic              sd_buff_wr,
  output logic              busy
);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH == 0 || NCH > 8 || TMO_W == 0) begin : g_param_chk
    $error("vdisk_arb: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            sd_rd_q, sd_rd_d;
  logic            sd_wr_q, sd_wr_d;
  logic [LBAW-1:0] sd_lba_q, sd_lba_d;
  logic [NCH-1:0]  ch_ack_q, ch_ack_d;
  logic [NCH-1:0]  ch_done_q, ch_done_d;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  grant_oh;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   pick_idx;
  logic            pick_vld;
  logic [LBAW-1:0] lba_arr [NCH];
  logic [DW-1:0]   din_arr [NCH];
`ifdef VDISK_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NCH-1:0]   ch_err_q, ch_err_d;
  logic             abort;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign lba_arr[i] = ch_lba[i*LBAW +: LBAW];
    assign din_arr[i] = ch_buff_din[i*DW +: DW];
  end

  assign pending  = ch_rd | ch_wr;
  assign grant_oh = NCH'(1) << grant_q;

  // First pending channel at or after the round-robin pointer
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = GW'((32'(rr_q) + i) % NCH);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    sd_lba_d  = sd_lba_q;
    ch_ack_d  = ch_ack_q;
    ch_done_d = '0;
`ifdef VDISK_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
    ch_err_d  = '0;
    abort     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A stale sd_ack from hps_io blocks new grants
        if (pick_vld && !sd_ack) begin
          state_d  = S_ISSUE;
          grant_d  = pick_idx;
          sd_lba_d = lba_arr[pick_idx];
          sd_rd_d  = ch_rd[pick_idx];
          sd_wr_d  = !ch_rd[pick_idx];
`ifdef VDISK_ARB_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (sd_ack) begin
          state_d  = S_XFER;
          sd_rd_d  = 1'b0;
          sd_wr_d  = 1'b0;
          ch_ack_d = grant_oh;
`ifdef VDISK_ARB_TIMEOUT_EN
          tmo_d    = '0;
        end else if (tmo_q == '1) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_XFER: begin
        if (!sd_ack) begin
          state_d   = S_DONE;
          ch_ack_d  = '0;
          ch_done_d = grant_oh;
`ifdef VDISK_ARB_TIMEOUT_EN
        end else if (tmo_q == '1) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = (32'(grant_q) == NCH - 1) ? '0 : grant_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
`ifdef VDISK_ARB_TIMEOUT_EN
    if (abort) begin
      state_d   = S_DONE;
      sd_rd_d   = 1'b0;
      sd_wr_d   = 1'b0;
      ch_ack_d  = '0;
      ch_done_d = grant_oh;
      ch_err_d  = grant_oh;
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      sd_lba_q  <= '0;
      ch_ack_q  <= '0;
      ch_done_q <= '0;
`ifdef VDISK_ARB_TIMEOUT_EN
      tmo_q     <= '0;
      ch_err_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      sd_lba_q  <= sd_lba_d;
      ch_ack_q  <= ch_ack_d;
      ch_done_q <= ch_done_d;
`ifdef VDISK_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
      ch_err_q  <= ch_err_d;
`endif
    end
  end

`ifdef VDISK_ARB_TIMEOUT_EN
  assign ch_err = ch_err_q;
`else
  assign ch_err = '0;
`endif

  // Buffer bus: broadcast from hps_io, strobe and write data steered by the grant
  assign ch_buff_addr = sd_buff_addr;
  assign ch_buff_dout = sd_buff_dout;
  assign ch_buff_wr   = (state_q == S_XFER && sd_buff_wr) ? grant_oh : '0;
  assign sd_buff_din  = din_arr[grant_q];

  assign sd_rd   = sd_rd_q;
  assign sd_wr   = sd_wr_q;
  assign sd_lba  = sd_lba_q;
  assign ch_ack  = ch_ack_q;
  assign ch_done = ch_done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_vdisk_arb.sv
// Directed bench for vdisk_arb: table of single transactions plus hand-written corner sequences.
module tb_vdisk_arb;
  localparam int unsigned NCH  = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 8;
  localparam int unsigned LBAW = 32;
`ifdef VDISK_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
`else
  localparam int unsigned TMO_W = 24;
`endif

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_rd, ch_wr;
  logic [NCH*LBAW-1:0] ch_lba;
  logic [NCH-1:0]    ch_ack, ch_done, ch_err, ch_buff_wr;
  logic [NCH*DW-1:0] ch_buff_din;
  logic [AW-1:0]     ch_buff_addr;
  logic [DW-1:0]     ch_buff_dout;
  logic              sd_rd, sd_wr, sd_ack, sd_buff_wr, busy;
  logic [LBAW-1:0]   sd_lba;
  logic [AW-1:0]     sd_buff_addr;
  logic [DW-1:0]     sd_buff_dout, sd_buff_din;

  logic [LBAW-1:0] lba [NCH];
  logic [DW-1:0]   din [NCH];
  assign ch_lba      = {lba[2], lba[1], lba[0]};
  assign ch_buff_din = {din[2], din[1], din[0]};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  vdisk_arb #(.NCH(NCH), .DW(DW), .AW(AW), .LBAW(LBAW), .TMO_W(TMO_W)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_lba(ch_lba),
    .ch_ack(ch_ack), .ch_done(ch_done), .ch_err(ch_err),
    .ch_buff_din(ch_buff_din), .ch_buff_wr(ch_buff_wr),
    .ch_buff_addr(ch_buff_addr), .ch_buff_dout(ch_buff_dout),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] l0, l1, l2;
    logic [2:0]  g;
    logic        is_rd;
    logic [31:0] lba;
    int          dly;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(sd_rd || sd_wr) && lat < 20);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sd_ack = 1'b0;
    ch_rd = '0;
    ch_wr = '0;
    step();
    check("rst_sd_req", 64'({sd_rd, sd_wr}), 64'd0);
    check("rst_ch_ack_done", 64'({ch_ack, ch_done, ch_err}), 64'd0);
    check("rst_sd_lba_busy", 64'({sd_lba, busy}), 64'd0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    if (v.rst) do_reset();
    lba[0] = v.l0; lba[1] = v.l1; lba[2] = v.l2;
    ch_rd = v.rd;
    ch_wr = v.wr;
    wait_req(lat);
    check($sformatf("v%0d_grant_latency", k), 64'(lat), 64'd1);
    check($sformatf("v%0d_rd_wr", k), 64'({sd_rd, sd_wr}), 64'({v.is_rd, !v.is_rd}));
    check($sformatf("v%0d_sd_lba", k), 64'(sd_lba), 64'(v.lba));
    check($sformatf("v%0d_busy", k), 64'(busy), 64'd1);
    repeat (v.dly) step();
    check($sformatf("v%0d_req_held", k), 64'({sd_rd, sd_wr, ch_ack}), 64'({v.is_rd, !v.is_rd, 3'b000}));
    sd_ack = 1'b1;
    step();
    check($sformatf("v%0d_ack_start", k), 64'({sd_rd, sd_wr, ch_ack}), 64'({2'b00, v.g}));
    repeat (2) step();
    check($sformatf("v%0d_ack_hold", k), 64'(ch_ack), 64'(v.g));
    sd_ack = 1'b0;
    step();
    check($sformatf("v%0d_done", k), 64'({ch_done, ch_ack, ch_err}), 64'({v.g, 3'b000, 3'b000}));
    if (v.is_rd) ch_rd = ch_rd & ~v.g;
    else         ch_wr = ch_wr & ~v.g;
    step();
    check($sformatf("v%0d_idle", k), 64'({ch_done, busy}), 64'd0);
  endtask

  initial begin
    int lat;
    int hits;
    int stray;
    reset = 1'b1;
    ch_rd = '0; ch_wr = '0; sd_ack = 1'b0;
    sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
    for (int i = 0; i < 3; i++) begin
      lba[i] = '0;
      din[i] = '0;
    end

    vecs[0] = '{rst:1'b1, rd:3'b001, wr:3'b000, l0:32'h100, l1:32'h111, l2:32'h122, g:3'b001, is_rd:1'b1, lba:32'h100, dly:4};
    vecs[1] = '{rst:1'b1, rd:3'b111, wr:3'b000, l0:32'h100, l1:32'h111, l2:32'h122, g:3'b001, is_rd:1'b1, lba:32'h100, dly:1};
    vecs[2] = '{rst:1'b0, rd:3'b111, wr:3'b000, l0:32'h100, l1:32'h111, l2:32'h122, g:3'b010, is_rd:1'b1, lba:32'h111, dly:0};
    vecs[3] = '{rst:1'b0, rd:3'b111, wr:3'b000, l0:32'h100, l1:32'h111, l2:32'h122, g:3'b100, is_rd:1'b1, lba:32'h122, dly:2};
    vecs[4] = '{rst:1'b0, rd:3'b111, wr:3'b000, l0:32'h100, l1:32'h111, l2:32'h122, g:3'b001, is_rd:1'b1, lba:32'h100, dly:0};
    vecs[5] = '{rst:1'b0, rd:3'b100, wr:3'b100, l0:32'h100, l1:32'h111, l2:32'h222, g:3'b100, is_rd:1'b1, lba:32'h222, dly:1};
    vecs[6] = '{rst:1'b0, rd:3'b000, wr:3'b100, l0:32'h100, l1:32'h111, l2:32'h222, g:3'b100, is_rd:1'b0, lba:32'h222, dly:1};
    vecs[7] = '{rst:1'b0, rd:3'b000, wr:3'b011, l0:32'h55,  l1:32'h66,  l2:32'h222, g:3'b001, is_rd:1'b0, lba:32'h55,  dly:0};
    vecs[8] = '{rst:1'b0, rd:3'b001, wr:3'b010, l0:32'h55,  l1:32'h66,  l2:32'h222, g:3'b010, is_rd:1'b0, lba:32'h66,  dly:3};
    vecs[9] = '{rst:1'b0, rd:3'b001, wr:3'b000, l0:32'h55,  l1:32'h66,  l2:32'h222, g:3'b001, is_rd:1'b1, lba:32'h55,  dly:0};

    step();
    reset = 1'b0;

    for (int k = 0; k < 10; k++) run_vec(k, vecs[k]);

    // Buffer steering on ch1: read strobes, then a write with ch1 data on sd_buff_din
    do_reset();
    din[0] = 16'h1111; din[1] = 16'hA5A5; din[2] = 16'h3333;
    lba[1] = 32'hB01;
    ch_rd = 3'b010;
    wait_req(lat);
    check("t3_grant_rd", 64'({sd_rd, sd_lba}), 64'({1'b1, 32'hB01}));
    check("t3_din_before_xfer", 64'(sd_buff_din), 64'h A5A5);
    sd_buff_wr = 1'b1;
    #1;
    check("t3_no_strobe_in_issue", 64'(ch_buff_wr), 64'd0);
    sd_buff_wr = 1'b0;
    sd_ack = 1'b1;
    step();
    hits = 0;
    stray = 0;
    for (int i = 0; i < 256; i++) begin
      sd_buff_wr = 1'b1;
      sd_buff_addr = AW'(i);
      sd_buff_dout = DW'(i * 257);
      #1;
      if (ch_buff_wr == 3'b010 && ch_buff_addr == AW'(i) && ch_buff_dout == DW'(i * 257)) hits++;
      if ((ch_buff_wr & 3'b101) != 3'b000) stray++;
      step();
    end
    check("t3_strobes_ch1", 64'(hits), 64'd256);
    check("t3_strobes_other", 64'(stray), 64'd0);
    sd_buff_wr = 1'b0;
    #1;
    check("t3_strobe_low", 64'(ch_buff_wr), 64'd0);
    sd_ack = 1'b0;
    step();
    check("t3_rd_done", 64'(ch_done), 64'b010);
    ch_rd = '0;
    step();
    ch_wr = 3'b010;
    wait_req(lat);
    check("t3_grant_wr", 64'({sd_rd, sd_wr}), 64'b01);
    sd_ack = 1'b1;
    step();
    check("t3_wr_din", 64'(sd_buff_din), 64'hA5A5);
    din[0] = 16'hFFFF;
    #1;
    check("t3_wr_din_isolated", 64'(sd_buff_din), 64'hA5A5);
    sd_ack = 1'b0;
    step();
    check("t3_wr_done", 64'(ch_done), 64'b010);
    ch_wr = '0;
    step();

    // Reset while in XFER: no completion, pointer back to ch0 (rr was 2)
    lba[0] = 32'h500; lba[2] = 32'h502;
    ch_rd = 3'b101;
    wait_req(lat);
    check("t5_grant_ch2", 64'(sd_lba), 64'h502);
    sd_ack = 1'b1;
    step();
    check("t5_in_xfer", 64'(ch_ack), 64'b100);
    reset = 1'b1;
    sd_ack = 1'b0;
    step();
    check("t5_after_reset", 64'({sd_rd, sd_wr, ch_ack, ch_done, busy}), 64'd0);
    reset = 1'b0;
    wait_req(lat);
    check("t5_regrant_lat", 64'(lat), 64'd1);
    check("t5_regrant_ch0", 64'({ch_done, sd_lba}), 64'({3'b000, 32'h500}));
    sd_ack = 1'b1;
    step();
    sd_ack = 1'b0;
    step();
    check("t5_done_ch0", 64'(ch_done), 64'b001);
    ch_rd = '0;
    step();

    // Stale sd_ack in IDLE blocks the grant; LBA sampled only at grant
    do_reset();
    lba[0] = 32'h700;
    sd_ack = 1'b1;
    ch_rd = 3'b001;
    repeat (3) step();
    check("stale_ack_no_grant", 64'({sd_rd, sd_wr, busy}), 64'd0);
    sd_ack = 1'b0;
    wait_req(lat);
    check("stale_ack_grant_lat", 64'(lat), 64'd1);
    lba[0] = 32'h7FF;
    step();
    check("lba_frozen_issue", 64'(sd_lba), 64'h700);
    sd_ack = 1'b1;
    step();
    step();
    check("lba_frozen_xfer", 64'(sd_lba), 64'h700);
    sd_ack = 1'b0;
    step();
    check("stale_ack_done", 64'(ch_done), 64'b001);
    ch_rd = '0;
    step();

`ifdef VDISK_ARB_TIMEOUT_EN
    // No sd_ack: abort with ch_err after the 4-bit counter saturates
    do_reset();
    ch_rd = 3'b010;
    wait_req(lat);
    lat = 0;
    while (ch_done == 3'b000 && lat < 40) begin
      step();
      lat++;
    end
    check("tmo_done_err", 64'({ch_done, ch_err, sd_rd}), 64'({3'b010, 3'b010, 1'b0}));
    check("tmo_cycles_in_range", 64'(lat >= 15 && lat <= 17), 64'd1);
    ch_rd = '0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
